// File: rtl/demorgan_pkg.sv
// ============================================================================
// Module : demorgan_pkg
// Brief  : Shared types, result-bit indices and golden model for the sweep controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package demorgan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int RES_NA      = 0;
    localparam int RES_NB      = 1;
    localparam int RES_NANDNB  = 2;
    localparam int RES_AANDB   = 3;
    localparam int RES_NAB     = 4;
    localparam int RES_NAORNB  = 5;
    localparam int RES_AORB    = 6;
    localparam int RES_NAORB   = 7;

    function automatic logic [7:0] golden(input logic a, input logic b);
        logic [7:0] r;
        r             = '0;
        r[RES_NA]     = ~a;
        r[RES_NB]     = ~b;
        r[RES_NANDNB] = ~a & ~b;
        r[RES_AANDB]  = a & b;
        r[RES_NAB]    = ~(a & b);
        r[RES_NAORNB] = ~a | ~b;
        r[RES_AORB]   = a | b;
        r[RES_NAORB]  = ~(a | b);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/demorgan_vec_counter.sv
// ============================================================================
// Module : demorgan_vec_counter
// Brief  : Vector index / sweep counter with wrap and last-vector flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demorgan_vec_counter #(
    parameter int REPEAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       adv_i,
    output logic [1:0] idx_o,
    output logic       last_o
);

    localparam int SWEEP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    logic [1:0]         idx_q,   idx_d;
    logic [SWEEP_W-1:0] sweep_q, sweep_d;

    assign last_o = (idx_q == 2'd3) && (sweep_q == SWEEP_W'(REPEAT - 1));
    assign idx_o  = idx_q;

    // Advancing past the last vector is a no-op; the controller leaves via DONE instead.
    always_comb begin
        idx_d   = idx_q;
        sweep_d = sweep_q;
        if (clr_i) begin
            idx_d   = 2'd0;
            sweep_d = '0;
        end else if (adv_i && !last_o) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                sweep_d = sweep_q + SWEEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= 2'd0;
            sweep_q <= '0;
        end else begin
            idx_q   <= idx_d;
            sweep_q <= sweep_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/demorgan_sweep_ctrl.sv
// ============================================================================
// Module : demorgan_sweep_ctrl
// Brief  : Self-test sequencer driving all {A,B} vectors into the demorgan gate block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demorgan_sweep_ctrl
    import demorgan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int REPEAT        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       dut_a_o,
    output logic       dut_b_o,
    input  logic [7:0] dut_res_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] fail_mask_o,
    output logic [7:0] err_count_o
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [3:0]          mask_q, mask_d;
    logic [7:0]          err_q, err_d;
    logic                pass_q, pass_d;

    logic       cnt_clr;
    logic       cnt_adv;
    logic [1:0] idx;
    logic       last_vec;
    logic       mismatch;

    demorgan_vec_counter #(
        .REPEAT (REPEAT)
    ) u_vec_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .adv_i  (cnt_adv),
        .idx_o  (idx),
        .last_o (last_vec)
    );

    assign mismatch = (dut_res_i != golden(idx[1], idx[0]));

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        mask_d   = mask_q;
        err_d    = err_q;
        pass_d   = pass_q;
        cnt_clr  = 1'b0;
        cnt_adv  = 1'b0;

        // Abort takes priority over everything in a busy state; clearing the counter
        // also returns the gate inputs to 00. Partial results are kept.
        if (state_q != ST_IDLE && abort_i) begin
            state_d  = ST_IDLE;
            settle_d = '0;
            pass_d   = 1'b0;
            cnt_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d  = ST_APPLY;
                        settle_d = '0;
                        mask_d   = 4'd0;
                        err_d    = 8'd0;
                        pass_d   = 1'b0;
                        cnt_clr  = 1'b1;
                    end
                end
                ST_APPLY: begin
                    if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        settle_d = '0;
                        state_d  = ST_SAMPLE;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        mask_d[idx] = 1'b1;
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                    end
                    if (last_vec) begin
                        state_d = ST_DONE;
                        pass_d  = (mask_d == 4'd0);
                    end else begin
                        cnt_adv = 1'b1;
                        state_d = ST_APPLY;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            mask_q   <= 4'd0;
            err_q    <= 8'd0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
        end
    end

    assign dut_a_o     = idx[1];
    assign dut_b_o     = idx[0];
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign pass_o      = pass_q;
    assign fail_mask_o = mask_q;
    assign err_count_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_demorgan_sweep_ctrl.sv
// ============================================================================
// Module : tb_demorgan_sweep_ctrl
// Brief  : Bench for demorgan_sweep_ctrl: default and (SETTLE=3, REPEAT=2) instances.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_demorgan_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start [2];
    logic       abort [2];
    logic       a_w   [2];
    logic       b_w   [2];
    logic       busy_w[2];
    logic       done_w[2];
    logic       pass_w[2];
    logic [3:0] mask_w[2];
    logic [7:0] err_w [2];
    logic [7:0] res   [2];
    logic [7:0] s0    [2];
    logic [7:0] s1    [2];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Reference gate outputs, bit7..bit0 = {nAorB,AorB,nAornB,nAB,AandB,nAandnB,nB,nA}
    function automatic logic [7:0] gold(input logic a, input logic b);
        return {~(a | b), a | b, ~a | ~b, ~(a & b), a & b, ~a & ~b, ~b, ~a};
    endfunction

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int repeat_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    assign res[0] = (gold(a_w[0], b_w[0]) & ~s0[0]) | s1[0];
    assign res[1] = (gold(a_w[1], b_w[1]) & ~s0[1]) | s1[1];

    demorgan_sweep_ctrl dut0 (
        .clk (clk), .rst_n (rst_n), .start_i (start[0]), .abort_i (abort[0]),
        .dut_a_o (a_w[0]), .dut_b_o (b_w[0]), .dut_res_i (res[0]),
        .busy_o (busy_w[0]), .done_o (done_w[0]), .pass_o (pass_w[0]),
        .fail_mask_o (mask_w[0]), .err_count_o (err_w[0])
    );

    demorgan_sweep_ctrl #(.SETTLE_CYCLES(3), .REPEAT(2)) dut1 (
        .clk (clk), .rst_n (rst_n), .start_i (start[1]), .abort_i (abort[1]),
        .dut_a_o (a_w[1]), .dut_b_o (b_w[1]), .dut_res_i (res[1]),
        .busy_o (busy_w[1]), .done_o (done_w[1]), .pass_o (pass_w[1]),
        .fail_mask_o (mask_w[1]), .err_count_o (err_w[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Model: m_t counts cycles since acceptance (0 = idle). Each vector occupies
    // SETTLE+1 cycles with the sample in its last one; done is at t = 4*(S+1)*R+1.
    int         m_t   [2];
    logic [1:0] m_ab  [2];
    logic [3:0] m_mask[2];
    int         m_err [2];
    logic       m_pass[2];
    int         mp, ml;

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            mp = settle_of(i) + 1;
            ml = 4 * mp * repeat_of(i) + 1;
            if (!rst_n) begin
                m_t[i] = 0; m_ab[i] = 2'd0; m_mask[i] = 4'd0; m_err[i] = 0; m_pass[i] = 1'b0;
            end else if (m_t[i] == 0) begin
                if (start[i]) begin
                    m_t[i] = 1; m_ab[i] = 2'd0; m_mask[i] = 4'd0; m_err[i] = 0; m_pass[i] = 1'b0;
                end
            end else if (abort[i]) begin
                m_t[i] = 0; m_ab[i] = 2'd0; m_pass[i] = 1'b0;
            end else if (m_t[i] == ml) begin
                m_t[i] = 0;
            end else begin
                if ((m_t[i] - 1) % mp == mp - 1) begin
                    if (((gold(m_ab[i][1], m_ab[i][0]) & ~s0[i]) | s1[i]) != gold(m_ab[i][1], m_ab[i][0])) begin
                        m_mask[i][m_ab[i]] = 1'b1;
                        if (m_err[i] < 255) m_err[i] = m_err[i] + 1;
                    end
                end
                m_t[i] = m_t[i] + 1;
                if (m_t[i] == ml) m_pass[i] = (m_mask[i] == 4'd0);
                else              m_ab[i]   = 2'(((m_t[i] - 1) / mp) % 4);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [16:0] exp_v, got_v;
                int          l;
                l     = 4 * (settle_of(i) + 1) * repeat_of(i) + 1;
                exp_v = {m_t[i] != 0, m_t[i] == l, m_ab[i], m_pass[i], m_mask[i], m_err[i][7:0]};
                got_v = {busy_w[i], done_w[i], a_w[i], b_w[i], pass_w[i], mask_w[i], err_w[i]};
                n_checks++;
                if (got_v !== exp_v) begin
                    n_err++;
                    $display("FAIL model inst%0d cyc%0d {busy,done,a,b,pass,mask,err} got=%h exp=%h",
                             i, cyc, got_v, exp_v);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] seq_p;

    // Pulses start for one cycle, then waits (bounded) for done; off = done cycle - start cycle.
    task automatic run(input int inst, output int off);
        int c0;
        off   = -1;
        seq_p = 16'd0;
        tick();
        c0 = cyc;
        start[inst] = 1'b1;
        tick();
        start[inst] = 1'b0;
        for (int k = 0; k < 80 && off < 0; k++) begin
            @(negedge clk);
            if (busy_w[inst] && !done_w[inst]) seq_p = {seq_p[13:0], a_w[inst], b_w[inst]};
            if (done_w[inst]) off = cyc - c0;
        end
        if (off < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL timeout inst%0d got=no_done exp=done", inst);
        end
    endtask

    initial begin
        int off, off1, off2, ndone, c0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; abort[i] = 1'b0; s0[i] = 8'd0; s1[i] = 8'd0;
        end
        repeat (3) tick();
        chk("rst_busy0", busy_w[0], 0);
        chk("rst_done0", done_w[0], 0);
        chk("rst_pass0", pass_w[0], 0);
        chk("rst_ab0",   {a_w[0], b_w[0]}, 0);
        chk("rst_mask1", mask_w[1], 0);
        chk("rst_err1",  err_w[1], 0);
        chk_en = 1'b1;
        #2 rst_n = 1'b1;

        // Clean default run
        run(0, off);
        chk("clean_done_cyc", off, 9);
        chk("clean_seq", seq_p, 16'h05AF);
        chk("clean_pass", pass_w[0], 1);
        chk("clean_mask", mask_w[0], 0);
        chk("clean_err", err_w[0], 0);

        // nAB stuck-0
        s0[0] = 8'h10;
        run(0, off);
        chk("nab_s0_done_cyc", off, 9);
        chk("nab_s0_mask", mask_w[0], 4'b0111);
        chk("nab_s0_err", err_w[0], 3);
        chk("nab_s0_pass", pass_w[0], 0);
        s0[0] = 8'd0;

        // SETTLE=3, REPEAT=2 with nAandnB stuck-1
        s1[1] = 8'h04;
        run(1, off);
        chk("long_done_cyc", off, 33);
        chk("long_mask", mask_w[1], 4'b1110);
        chk("long_err", err_w[1], 6);
        chk("long_pass", pass_w[1], 0);
        s1[1] = 8'd0;

        // Abort at cycle 4 together with a start, keeps the partial result of vector 0
        s0[0] = 8'h10;
        tick();
        c0 = cyc;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        while (cyc < c0 + 4) tick();
        abort[0] = 1'b1;
        start[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        start[0] = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy_w[0], 0);
        chk("abort_ab", {a_w[0], b_w[0]}, 0);
        chk("abort_pass", pass_w[0], 0);
        chk("abort_mask", mask_w[0], 4'b0001);
        chk("abort_err", err_w[0], 1);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_w[0] || busy_w[0]) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        s0[0] = 8'd0;
        run(0, off);
        chk("post_abort_done_cyc", off, 9);
        chk("post_abort_pass", pass_w[0], 1);

        // start held high: one run per IDLE visit, second run cleared and clean
        s0[0] = 8'h10;
        tick();
        c0 = cyc;
        start[0] = 1'b1;
        ndone = 0; off1 = -1; off2 = -1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done_w[0]) begin
                ndone++;
                if (ndone == 1) begin
                    off1 = cyc - c0;
                    chk("held_run1_mask", mask_w[0], 4'b0111);
                    s0[0] = 8'd0;
                end else if (ndone == 2) begin
                    off2 = cyc - c0;
                    chk("held_run2_mask", mask_w[0], 0);
                    chk("held_run2_err", err_w[0], 0);
                    chk("held_run2_pass", pass_w[0], 1);
                end
            end
        end
        chk("held_done_count", ndone, 2);
        chk("held_done1_cyc", off1, 9);
        chk("held_done2_cyc", off2, 19);
        tick();
        start[0] = 1'b0;
        repeat (15) tick();

        // Asynchronous reset in the middle of a SAMPLE cycle
        s0[0] = 8'h10;
        tick();
        c0 = cyc;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        while (cyc < c0 + 4) tick();
        chk("pre_rst_err", err_w[0], 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_w[0], 0);
        chk("arst_ab", {a_w[0], b_w[0]}, 0);
        chk("arst_mask", mask_w[0], 0);
        chk("arst_err", err_w[0], 0);
        chk("arst_pass_done", {pass_w[0], done_w[0]}, 0);
        #1 rst_n = 1'b1;
        s0[0] = 8'd0;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done_w[0]) ndone++;
        end
        chk("arst_no_done", ndone, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
